// File: rtl/vga_capture.sv
// vga_capture: locks to a TinyVGA PMOD raster and emits registered pixel coordinates/colour.
// Define VGA_CAPTURE_CRC_EN to build the per-frame CRC-16-CCITT; otherwise frame_crc/crc_valid are tied low.
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int H_OFFSET    = 143,
  parameter int V_OFFSET    = 35,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  vga_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);
  localparam logic [10:0] HO  = 11'(H_OFFSET);
  localparam logic [10:0] HE  = 11'(H_OFFSET + H_DISPLAY);
  localparam logic [10:0] HT  = 11'(H_TOTAL);
  localparam logic [10:0] HTO = 11'(2 * H_TOTAL);
  localparam logic [9:0]  VO  = 10'(V_OFFSET);
  localparam logic [9:0]  VE  = 10'(V_OFFSET + V_DISPLAY);
  localparam logic [9:0]  VT  = 10'(V_TOTAL);
  localparam logic [7:0]  LF  = 8'(LOCK_FRAMES);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  state_t      state_q;
  logic        hs_q, vs_q, bad_q, sync_err_q, pix_valid_q, frame_start_q;
  logic [10:0] hc_q, hc_d;
  logic [9:0]  lc_q, lc_d, x_d, y_d, pix_x_q, pix_y_q;
  logic [7:0]  good_q;
  logic [5:0]  rgb_d, pix_rgb_q;
  logic        hs_rise, vs_rise, line_bad, frame_good, lose, gain, lock_nx, valid_d;
  always_comb begin
    hs_rise    = vga_in[7] & ~hs_q;
    vs_rise    = vga_in[3] & ~vs_q;
    hc_d       = hs_rise ? 11'd0 : hc_q + {10'd0, hc_q != 11'h7FF};
    lc_d       = vs_rise ? {9'd0, hs_rise} : lc_q + {9'd0, hs_rise && lc_q != 10'h3FF};
    line_bad   = (hs_rise && hc_q + 11'd1 != HT) || hc_d == HTO;
    frame_good = lc_q == VT && !bad_q;
    lose       = line_bad || (vs_rise && state_q != UNLOCKED && !frame_good);
    gain       = vs_rise && state_q == ACQUIRE && frame_good && good_q + 8'd1 == LF;
    lock_nx    = !lose && (state_q == LOCKED || gain);
    x_d        = 10'(hc_d - HO);
    y_d        = lc_d - VO;
    valid_d    = lock_nx && hc_d >= HO && hc_d < HE && lc_d >= VO && lc_d < VE;
    rgb_d      = {vga_in[0], vga_in[4], vga_in[1], vga_in[5], vga_in[2], vga_in[6]};
  end
  // pix_valid follows the next lock state so a lost lock blanks pixels in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= UNLOCKED;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      bad_q         <= 1'b0;
      hc_q          <= '0;
      lc_q          <= '0;
      good_q        <= '0;
      sync_err_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= vga_in[7];
      vs_q          <= vga_in[3];
      hc_q          <= hc_d;
      lc_q          <= lc_d;
      bad_q         <= vs_rise ? line_bad : bad_q | line_bad;
      state_q       <= lose ? UNLOCKED : !vs_rise ? state_q : state_q == UNLOCKED ? ACQUIRE : gain ? LOCKED : state_q;
      good_q        <= lose ? 8'd0 : (vs_rise && state_q == ACQUIRE) ? good_q + 8'd1 : good_q;
      sync_err_q    <= sync_err_q | (lose && state_q == LOCKED);
      pix_valid_q   <= valid_d;
      pix_x_q       <= valid_d ? x_d : '0;
      pix_y_q       <= valid_d ? y_d : '0;
      pix_rgb_q     <= valid_d ? rgb_d : '0;
      frame_start_q <= valid_d && x_d == 10'd0 && y_d == 10'd0;
    end
  end
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign locked      = state_q == LOCKED;
  assign sync_err    = sync_err_q;
`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] crc8(input logic [15:0] c, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
  logic [15:0] crc_q, crc_d, fcrc_q;
  logic        crcv_q, last_px;
  // absorb from the registered stream so frame_start reseeds on the pixel it marks
  assign crc_d   = crc8(frame_start_q ? 16'hFFFF : crc_q, {2'b00, pix_rgb_q});
  assign last_px = pix_valid_q && pix_x_q == 10'(H_DISPLAY - 1) && pix_y_q == 10'(V_DISPLAY - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q  <= '0;
      fcrc_q <= '0;
      crcv_q <= 1'b0;
    end else begin
      crc_q  <= pix_valid_q ? crc_d : crc_q;
      fcrc_q <= last_px ? crc_d : fcrc_q;
      crcv_q <= last_px;
    end
  end
  assign frame_crc = fcrc_q;
  assign crc_valid = crcv_q;
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives a scaled-down raster into vga_capture and scoreboards the recovered pixel stream.
module tb_vga_capture;
  localparam int HT = 40, VT = 20, HD = 16, VD = 12, HO = 16, VO = 6, HS0 = 24, VS0 = 14;
  localparam int PER = HT * VT;
  logic        clk = 1'b0, reset = 1'b1, rst_req = 1'b0;
  logic [7:0]  vga_in = '0;
  logic        pix_valid, frame_start, locked, sync_err, crc_valid;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [15:0] frame_crc;
  typedef struct packed {logic [9:0] x; logic [9:0] y; logic [5:0] rgb;} pix_t;
  pix_t        q[$];
  logic [15:0] crc_hist[$];
  int          n_cmp = 0, n_mis = 0, h = 0, v = 0, rises = 0, kill_v = -1, mode = 0;
  int          vcnt = 0, cyc = 0, fs_prev = -1;
  logic        zero = 1'b0, vs_prev = 1'b0;
  logic [15:0] crc_m = '0, crc_exp = '0;
  always #5 clk = ~clk;
  vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_DISPLAY(HD), .V_DISPLAY(VD),
                .H_OFFSET(HO), .V_OFFSET(VO), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .vga_in(vga_in), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
    .sync_err(sync_err), .frame_crc(frame_crc), .crc_valid(crc_valid));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r = c;
    for (int i = 7; i >= 0; i--) r = r[15] ^ d[i] ? (r << 1) ^ 16'h1021 : r << 1;
    return r;
  endfunction
`endif
  // one raster sample per cycle; pixels expected only after the third vsync rise since the last disturbance
  task automatic step();
    logic hs, vs;
    logic [5:0] rgb;
    @(negedge clk);
    reset = rst_req;
    hs  = h >= HS0 && h < HS0 + 4 && v != kill_v && !zero;
    vs  = (v == VS0 || v == VS0 + 1) && !zero;
    rgb = (h < HD && v < VD && !zero) ?
          (mode == 0 ? 6'(h) : (mode == 2 && h == 10 && v == 10) ? 6'h3F : 6'h00) : 6'h00;
    vga_in = {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
    if (vs && !vs_prev) rises++;
    vs_prev = vs;
    if (h < HD && v < VD && rises >= 3) q.push_back('{x: 10'(h), y: 10'(v), rgb: rgb});
    h = (h == HT - 1) ? 0 : h + 1;
    if (h == 0) v = (v == VT - 1) ? 0 : v + 1;
  endtask
  task automatic run_to(input int tv, input int th);
    while (!(v == tv && h == th)) step();
  endtask
  task automatic frame();
    vcnt = 0;
    step();
    run_to(VS0, 0);
    chk("pix_count", 32'(vcnt), 32'(HD * VD));
    chk("queue_empty", 32'(q.size()), 0);
  endtask
  task automatic lock_seq();
    for (int k = 0; k < 2; k++) begin
      run_to(VS0, 0);
      step();
    end
    run_to(VS0, 0);
    step();
    chk("locked_before_3rd", 32'(locked), 0);
    step();
    chk("locked_at_3rd", 32'(locked), 1);
  endtask
  always @(negedge clk) begin
    pix_t e;
    cyc++;
    if (pix_valid) begin
      vcnt++;
      if (q.size() == 0) chk("spurious_valid", 32'(pix_valid), 0);
      else begin
        e = q.pop_front();
        chk("pix_x", 32'(pix_x), 32'(e.x));
        chk("pix_y", 32'(pix_y), 32'(e.y));
        chk("pix_rgb", 32'(pix_rgb), 32'(e.rgb));
`ifdef VGA_CAPTURE_CRC_EN
        crc_m = crc_model((e.x == 0 && e.y == 0) ? 16'hFFFF : crc_m, {2'b00, e.rgb});
        if (e.x == 10'(HD - 1) && e.y == 10'(VD - 1)) crc_exp = crc_m;
`endif
      end
    end
    if (frame_start) begin
      chk("fs_x", 32'(pix_x), 0);
      chk("fs_y", 32'(pix_y), 0);
      if (fs_prev >= 0) chk("fs_period", 32'(cyc - fs_prev), 32'(PER));
      fs_prev = cyc;
    end
    if (crc_valid) begin
`ifdef VGA_CAPTURE_CRC_EN
      chk("frame_crc", 32'(frame_crc), 32'(crc_exp));
`endif
      crc_hist.push_back(frame_crc);
    end
    if (!locked) fs_prev = -1;
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pix", 32'({pix_valid, pix_x, pix_y, pix_rgb, frame_start}), 0);
    chk("rst_stat", 32'({locked, sync_err, crc_valid, frame_crc}), 0);
    lock_seq();
    chk("sync_err_clean", 32'(sync_err), 0);
    frame();
    frame();
    mode = 1;
    crc_hist.delete();
    frame();
    frame();
    mode = 2;
    frame();
    mode = 1;
    frame();
`ifdef VGA_CAPTURE_CRC_EN
    chk("crc_count", 32'(crc_hist.size()), 4);
    if (crc_hist.size() == 4) begin
      chk("crc_repeat", 32'(crc_hist[1]), 32'(crc_hist[0]));
      chk("crc_flip_differs", 32'(crc_hist[2] != crc_hist[1]), 1);
      chk("crc_restored", 32'(crc_hist[3]), 32'(crc_hist[1]));
    end
`else
    chk("crc_valid_never", 32'(crc_hist.size()), 0);
    chk("frame_crc_zero", 32'(frame_crc), 0);
`endif
    mode = 0;
    run_to(5, 16);
    kill_v = 5;
    rises = 0;
    run_to(7, 0);
    chk("glitch_unlock", 32'(locked), 0);
    chk("glitch_sync_err", 32'(sync_err), 1);
    kill_v = -1;
    lock_seq();
    chk("sync_err_sticky", 32'(sync_err), 1);
    frame();
    run_to(2, 16);
    zero = 1'b1;
    rises = 0;
    repeat (100) step();
    chk("timeout_unlock", 32'(locked), 0);
    chk("timeout_blank", 32'(pix_valid), 0);
    zero = 1'b0;
    lock_seq();
    frame();
    run_to(6, 8);
    chk("pre_reset_valid", 32'(pix_valid), 1);
    rises = 0;
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("midrst_pix", 32'({pix_valid, pix_x, pix_y, pix_rgb, frame_start}), 0);
    chk("midrst_stat", 32'({locked, sync_err, crc_valid, frame_crc}), 0);
    lock_seq();
    chk("sync_err_after_reset", 32'(sync_err), 0);
    frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
